// File: rtl/ex_mem_pipe_stage.sv
// Purpose : elastic EX->MEM pipeline register with flush, bubble-masked controls and stall counter.
// Latency : one cycle from accept to out_valid when the stage is empty.
// Backpr. : SKID=1 buffers one extra entry so in_ready comes straight from a flop; SKID=0 passes out_ready through to in_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready + in_* payload           : EX-side handshake
//   flush                                      : squash held and incoming entries
//   out_valid/out_ready + out_* payload        : MEM-side handshake, controls masked by out_valid
//   stall_cnt                                  : saturating count of cycles with out_valid & ~out_ready
module ex_mem_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int MTR_W   = 2,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc_p4,
  input  logic [DATA_W-1:0]  in_alu_out,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [MTR_W-1:0]   in_mem_to_reg,
  input  logic               in_mem_write,
  input  logic               in_mem_read,
  input  logic               in_reg_write,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc_p4,
  output logic [DATA_W-1:0]  out_alu_out,
  output logic [DATA_W-1:0]  out_rt_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic [MTR_W-1:0]   out_mem_to_reg,
  output logic               out_mem_write,
  output logic               out_mem_read,
  output logic               out_reg_write,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]  pc_p4;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  rt_data;
    logic [RADDR_W-1:0] rd;
    logic [MTR_W-1:0]   mem_to_reg;
    logic               mem_write;
    logic               mem_read;
    logic               reg_write;
  } pay_t;

  pay_t             in_pay;
  pay_t             main_q, main_d;
  pay_t             skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             consume;

  assign in_pay = '{pc_p4:      in_pc_p4,
                    alu_out:    in_alu_out,
                    rt_data:    in_rt_data,
                    rd:         in_rd,
                    mem_to_reg: in_mem_to_reg,
                    mem_write:  in_mem_write,
                    mem_read:   in_mem_read,
                    reg_write:  in_reg_write};

  // With a skid entry, ready only depends on whether the spare slot is
  // occupied, which breaks the combinational path from out_ready.
  assign in_ready = (SKID != 0) ? ~skid_vld_q : (~main_vld_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    stall_d    = stall_q;

    if (main_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    if (flush) begin
      // Squash wins over any handshake; payload left stale on purpose.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (SKID != 0) begin
      if (consume) begin
        if (skid_vld_q) begin
          // in_ready is low here, so no accept can collide with the refill.
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          main_d = in_pay;
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (accept) begin
        if (main_vld_q) begin
          skid_d     = in_pay;
          skid_vld_d = 1'b1;
        end else begin
          main_d     = in_pay;
          main_vld_d = 1'b1;
        end
      end
    end else begin
      if (accept) begin
        main_d     = in_pay;
        main_vld_d = 1'b1;
      end else if (consume) begin
        main_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      stall_q    <= stall_d;
    end
  end

  assign out_valid      = main_vld_q;
  assign out_pc_p4      = main_q.pc_p4;
  assign out_alu_out    = main_q.alu_out;
  assign out_rt_data    = main_q.rt_data;
  assign out_rd         = main_q.rd;
  assign out_mem_to_reg = main_q.mem_to_reg;
  // Controls must never fire on a bubble, even with stale payload held.
  assign out_mem_write  = main_q.mem_write & main_vld_q;
  assign out_mem_read   = main_q.mem_read  & main_vld_q;
  assign out_reg_write  = main_q.reg_write & main_vld_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: DUT a is SKID=1/CNT_W=4, DUT b is SKID=0/CNT_W=16.
// Both share stimulus; each has its own FIFO scoreboard and stall-count model.
module tb_ex_mem_pipe_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc_p4, in_alu_out, in_rt_data;
  logic [4:0]  in_rd;
  logic [1:0]  in_mem_to_reg;
  logic        in_mem_write, in_mem_read, in_reg_write;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_pc, a_alu, a_rt;
  logic [4:0]  a_rd;
  logic [1:0]  a_mtr;
  logic        a_mw, a_mr, a_rw;
  logic [3:0]  a_stall;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_pc, b_alu, b_rt;
  logic [4:0]  b_rd;
  logic [1:0]  b_mtr;
  logic        b_mw, b_mr, b_rw;
  logic [15:0] b_stall;

  logic [105:0] in_pay, a_pay, b_pay;
  assign in_pay = {in_pc_p4, in_alu_out, in_rt_data, in_rd, in_mem_to_reg,
                   in_mem_write, in_mem_read, in_reg_write};
  assign a_pay  = {a_pc, a_alu, a_rt, a_rd, a_mtr, a_mw, a_mr, a_rw};
  assign b_pay  = {b_pc, b_alu, b_rt, b_rd, b_mtr, b_mw, b_mr, b_rw};

  ex_mem_pipe_stage #(.DATA_W(32), .RADDR_W(5), .MTR_W(2), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc_p4(in_pc_p4), .in_alu_out(in_alu_out), .in_rt_data(in_rt_data),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read), .in_reg_write(in_reg_write), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc_p4(a_pc),
    .out_alu_out(a_alu), .out_rt_data(a_rt), .out_rd(a_rd), .out_mem_to_reg(a_mtr),
    .out_mem_write(a_mw), .out_mem_read(a_mr), .out_reg_write(a_rw), .stall_cnt(a_stall));

  ex_mem_pipe_stage #(.DATA_W(32), .RADDR_W(5), .MTR_W(2), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc_p4(in_pc_p4), .in_alu_out(in_alu_out), .in_rt_data(in_rt_data),
    .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read), .in_reg_write(in_reg_write), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc_p4(b_pc),
    .out_alu_out(b_alu), .out_rt_data(b_rt), .out_rd(b_rd), .out_mem_to_reg(b_mtr),
    .out_mem_write(b_mw), .out_mem_read(b_mr), .out_reg_write(b_rw), .stall_cnt(b_stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [105:0] qa[$];
  logic [105:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic rw,
                       input logic mw, input logic mr, input logic fl, input logic ordy);
    in_valid      = v;
    in_alu_out    = alu;
    in_pc_p4      = alu + 32'd4;
    in_rt_data    = ~alu;
    in_rd         = alu[4:0] ^ 5'h1f;
    in_mem_to_reg = alu[5:4];
    in_reg_write  = rw;
    in_mem_write  = mw;
    in_mem_read   = mr;
    flush         = fl;
    out_ready     = ordy;
  endtask

  // Skid stage modelled as a FIFO of depth 2.
  task automatic model_a();
    logic cons, acc;
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    if (qa.size() != 0) chk("a_payload", a_pay, qa[0]);
    else chk("a_ctl_masked", {a_mw, a_mr, a_rw}, 0);
    chk("a_stall_cnt", a_stall, cnt_a);
    cons = (qa.size() != 0) && out_ready;
    acc  = in_valid && (qa.size() < 2);
    if (!out_ready && qa.size() != 0 && cnt_a < 15) cnt_a++;
    if (cons) void'(qa.pop_front());
    if (flush) qa.delete();
    else if (acc) qa.push_back(in_pay);
  endtask

  // Single-entry stage: ready whenever empty or being drained.
  task automatic model_b();
    logic cons, acc, rdy;
    rdy = (qb.size() == 0) || out_ready;
    chk("b_in_ready", b_in_ready, rdy);
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    if (qb.size() != 0) chk("b_payload", b_pay, qb[0]);
    else chk("b_ctl_masked", {b_mw, b_mr, b_rw}, 0);
    chk("b_stall_cnt", b_stall, cnt_b);
    cons = (qb.size() != 0) && out_ready;
    acc  = in_valid && rdy;
    if (!out_ready && qb.size() != 0 && cnt_b < 65535) cnt_b++;
    if (cons) void'(qb.pop_front());
    if (flush) qb.delete();
    else if (acc) qb.push_back(in_pay);
  endtask

  // Inputs are set at a falling edge; checks run 1 time unit later.
  task automatic cyc();
    #1;
    model_a();
    model_b();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_a_out_valid"}, a_out_valid, 0);
    chk({tag, "_a_outputs"}, a_pay, 0);
    chk({tag, "_a_in_ready"}, a_in_ready, 1);
    chk({tag, "_a_stall"}, a_stall, 0);
    chk({tag, "_b_out_valid"}, b_out_valid, 0);
    chk({tag, "_b_outputs"}, b_pay, 0);
    chk({tag, "_b_in_ready"}, b_in_ready, 1);
    chk({tag, "_b_stall"}, b_stall, 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Stream at full throughput.
    drive(1, 32'h10, 1, 0, 0, 0, 1); cyc();
    drive(1, 32'h20, 0, 1, 0, 0, 1); cyc();
    drive(1, 32'h30, 1, 0, 1, 0, 1); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 1); cyc(); cyc();
    #1 chk("stream_stall_a", a_stall, 0);

    // Back-pressure: A fills main and skid.
    drive(1, 32'hA, 1, 0, 0, 0, 0); cyc();
    drive(1, 32'hB, 0, 0, 1, 0, 0); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #1;
    chk("bp_a_main", a_alu, 32'hA);
    chk("bp_a_in_ready", a_in_ready, 0);
    cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 1); cyc(); cyc(); cyc();
    #1 chk("bp_a_stall", a_stall, 2);

    // Flush with a concurrent accept.
    drive(1, 32'h55, 1, 1, 0, 0, 0); cyc();
    drive(1, 32'h66, 1, 1, 1, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 1);
    #1;
    chk("flush_a_valid", a_out_valid, 0);
    chk("flush_a_ctl", {a_mw, a_mr, a_rw}, 0);
    chk("flush_b_ctl", {b_mw, b_mr, b_rw}, 0);
    cyc(); cyc();

    // SKID=0 accept-and-consume in one cycle.
    drive(1, 32'h70, 1, 0, 0, 0, 1); cyc();
    drive(1, 32'h80, 0, 1, 0, 0, 1);
    #1;
    chk("bypass_b_in_ready", b_in_ready, 1);
    chk("bypass_b_valid", b_out_valid, 1);
    cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 1);
    #1 chk("bypass_b_next", b_alu, 32'h80);
    cyc();

    // Counter saturation on the 4-bit instance.
    drive(1, 32'h90, 1, 0, 0, 0, 0); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    repeat (20) cyc();
    #1 chk("sat_a_stall", a_stall, 15);

    // Async reset with both A entries full.
    drive(1, 32'h91, 1, 1, 0, 0, 0); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("areset");
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(negedge clk);
    reset = 1'b1;

    drive(1, 32'hC0, 1, 0, 1, 0, 1); cyc();
    drive(0, 32'h0, 0, 0, 0, 0, 1); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
